// File: rtl/scr1_tapc_pkg.sv
// Shared definitions for the oversampled TAP controller: TAP state encoding,
// architected IR codes and internal data-register widths.
package scr1_tapc_pkg;

    // 16-state IEEE 1149.1 TAP controller
    typedef enum logic [3:0] {
        TAP_TLR,
        TAP_RTI,
        TAP_SEL_DR,
        TAP_CAP_DR,
        TAP_SHIFT_DR,
        TAP_EXIT1_DR,
        TAP_PAUSE_DR,
        TAP_EXIT2_DR,
        TAP_UPD_DR,
        TAP_SEL_IR,
        TAP_CAP_IR,
        TAP_SHIFT_IR,
        TAP_EXIT1_IR,
        TAP_PAUSE_IR,
        TAP_EXIT2_IR,
        TAP_UPD_IR
    } tap_state_e;

    // Architected instruction codes (zero-extended to the IR width in use;
    // BYPASS is all-ones at any width)
    localparam logic [4:0] TAP_IR_IDCODE = 5'h01;
    localparam logic [4:0] TAP_IR_BLD_ID = 5'h04;
    localparam logic [4:0] TAP_IR_BYPASS = 5'h1f;

    // Internal data-register widths
    localparam int TAP_DR_IDCODE_W = 32;
    localparam int TAP_DR_BYPASS_W = 1;
    localparam int TAP_DR_BLD_ID_W = 32;

    // Standard TAP transition table, evaluated on a TCK rise
    function automatic tap_state_e tap_next_state(input tap_state_e state, input logic tms);
        tap_state_e nxt;
        nxt = TAP_TLR;
        case (state)
            TAP_TLR:      nxt = tms ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      nxt = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   nxt = tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   nxt = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: nxt = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: nxt = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: nxt = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: nxt = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   nxt = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   nxt = tms ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   nxt = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: nxt = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: nxt = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: nxt = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: nxt = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   nxt = tms ? TAP_SEL_DR   : TAP_RTI;
            default:      nxt = TAP_TLR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/scr1_tapc_ovs_dr.sv
// Generic TAP data register: parallel capture, serial shift (TDI in at the
// MSB, serial out from the LSB). Enables are one-clk event strobes.
module scr1_tapc_ovs_dr #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic             shift,
    input  logic             tdi,
    input  logic [WIDTH-1:0] capture_value,
    output logic             sout
);

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shifted;

    if (WIDTH == 1) begin : g_single
        assign shifted = tdi;
    end else begin : g_multi
        assign shifted = {tdi, sreg[WIDTH-1:1]};
    end

    // Capture has priority over shift; the TAP never asserts both together
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values;
        // a blocking = here would let later statements see already-updated bits.
        // NOTE: the register is cleared on reset even though Capture overwrites
        // it, so a scan right after reset shifts out zeros instead of X.
        if (!rst_n) begin
            sreg <= '0;
        end else if (capture) begin
            sreg <= capture_value;
        end else if (shift) begin
            sreg <= shifted;
        end
    end

    assign sout = sreg[0];

endmodule

// File: rtl/scr1_tapc_ovs.sv
// Oversampled, parametrised JTAG TAP controller. TCK/TMS/TDI/TRST_N are
// sampled by the core clock; all TAP actions are one-clk events qualified by
// detected TCK edges, so no TCK clock domain exists in the design.
// Optional build: define SCR1_TAPC_OVS_BLD_ID_EN to add the 32-bit BLD_ID DR
// (IR code 5'h04); without it that code decodes to BYPASS.
module scr1_tapc_ovs
    import scr1_tapc_pkg::*;
#(
    parameter int          IR_WIDTH     = 5,
    parameter int unsigned CH_IR_BASE   = 'h10,
    parameter int          CH_NUM       = 3,
    parameter int          SYNC_STAGES  = 2,
    parameter logic [31:0] BLD_ID_VALUE = 32'h2201_1200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tapc_trst_n,
    input  logic              tapc_tck,
    input  logic              tapc_tms,
    input  logic              tapc_tdi,
    output logic              tapc_tdo,
    output logic              tapc_tdo_en,
    input  logic [31:0]       fuse_idcode_i,
    output logic [CH_NUM-1:0] ch_sel_o,
    output logic              ch_capture_o,
    output logic              ch_shift_o,
    output logic              ch_update_o,
    output logic              ch_tdi_o,
    input  logic [CH_NUM-1:0] ch_tdo_i
);

    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(TAP_IR_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_BYPASS = {IR_WIDTH{TAP_IR_BYPASS[0]}};

    // ------------------------------------------------------------------
    // Pin synchronisers and TCK edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] tck_sync;
    logic [SYNC_STAGES-1:0] tms_sync;
    logic [SYNC_STAGES-1:0] tdi_sync;
    logic [SYNC_STAGES-1:0] trst_sync;
    logic                   tck_level;
    logic                   tms_s;
    logic                   tdi_s;
    logic                   trst_n_s;
    logic                   tck_rise;
    logic                   tck_fall;
    logic                   tap_rst_n;

    // Shift all four pins through identical chains so TMS/TDI stay aligned with TCK.
    // TCK resets high so a pin already high after reset never produces a rise;
    // a spurious fall in Test-Logic-Reset has no effect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tck_sync  <= '1;
            tms_sync  <= '0;
            tdi_sync  <= '0;
            trst_sync <= '0;
        end else begin
            tck_sync  <= {tck_sync[SYNC_STAGES-2:0],  tapc_tck};
            tms_sync  <= {tms_sync[SYNC_STAGES-2:0],  tapc_tms};
            tdi_sync  <= {tdi_sync[SYNC_STAGES-2:0],  tapc_tdi};
            trst_sync <= {trst_sync[SYNC_STAGES-2:0], tapc_trst_n};
        end
    end

    // Settled TCK level; it only flips once every synchroniser stage agrees,
    // so a pulse shorter than the chain loses both of its edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tck_level <= 1'b1;
        end else if (tck_rise) begin
            tck_level <= 1'b1;
        end else if (tck_fall) begin
            tck_level <= 1'b0;
        end
    end

    assign tck_rise  = (&tck_sync)  & ~tck_level;
    assign tck_fall  = ~(|tck_sync) &  tck_level;
    assign tms_s     = tms_sync[SYNC_STAGES-1];
    assign tdi_s     = tdi_sync[SYNC_STAGES-1];
    assign trst_n_s  = trst_sync[SYNC_STAGES-1];
    assign tap_rst_n = rst_n & trst_n_s;

    // ------------------------------------------------------------------
    // TAP state machine
    // ------------------------------------------------------------------
    tap_state_e state;
    tap_state_e state_next;

    // State register; either reset source returns the TAP to Test-Logic-Reset
    always_ff @(posedge clk) begin
        if (!tap_rst_n) begin
            state <= TAP_TLR;
        end else begin
            state <= state_next;
        end
    end

    // Advance on TMS only when a TCK rise was detected this clk
    always_comb begin
        // NOTE: the default assignment first keeps this block purely
        // combinational; a path that left state_next unassigned would infer a latch.
        state_next = state;
        if (tck_rise) begin
            state_next = tap_next_state(state, tms_s);
        end
    end

    // ------------------------------------------------------------------
    // Instruction register
    // ------------------------------------------------------------------
    logic [IR_WIDTH-1:0] ir;
    logic [IR_WIDTH-1:0] ir_shift;

    // Capture/shift on rise, update on the Update-IR fall; entering TLR restores IDCODE
    always_ff @(posedge clk) begin
        if (!tap_rst_n) begin
            ir       <= IR_IDCODE;
            ir_shift <= '0;
        end else if (tck_rise) begin
            if (state == TAP_CAP_IR) begin
                ir_shift <= IR_WIDTH'(1);
            end else if (state == TAP_SHIFT_IR) begin
                ir_shift <= {tdi_s, ir_shift[IR_WIDTH-1:1]};
            end
            if (state_next == TAP_TLR) begin
                ir <= IR_IDCODE;
            end
        end else if (tck_fall && state == TAP_UPD_IR) begin
            ir <= ir_shift;
        end
    end

    // ------------------------------------------------------------------
    // Instruction decode and internal data registers
    // ------------------------------------------------------------------
    logic              sel_idcode;
    logic              sel_bypass;
    logic [CH_NUM-1:0] ch_sel;
    logic              dr_capture;
    logic              dr_shift;
    logic              idcode_sout;
    logic              bypass_sout;
    logic              dr_tdo;

    assign dr_capture = tck_rise & (state == TAP_CAP_DR);
    assign dr_shift   = tck_rise & (state == TAP_SHIFT_DR);

`ifdef SCR1_TAPC_OVS_BLD_ID_EN
    localparam logic [IR_WIDTH-1:0] IR_BLD_ID = IR_WIDTH'(TAP_IR_BLD_ID);
    logic sel_bld_id;
    logic bld_id_sout;

    assign sel_bld_id = (ir == IR_BLD_ID);

    scr1_tapc_ovs_dr #(
        .WIDTH (TAP_DR_BLD_ID_W)
    ) i_bld_id_dr (
        .clk           (clk),
        .rst_n         (tap_rst_n),
        .capture       (dr_capture & sel_bld_id),
        .shift         (dr_shift & sel_bld_id),
        .tdi           (tdi_s),
        .capture_value (BLD_ID_VALUE),
        .sout          (bld_id_sout)
    );
`else
    logic bld_id_unused;
    assign bld_id_unused = (^BLD_ID_VALUE) ^ (^TAP_IR_BLD_ID) ^ TAP_DR_BLD_ID_W[0];
`endif

    // Decode IR into one DR select; unrecognised codes fall back to BYPASS
    always_comb begin
        sel_idcode = (ir == IR_IDCODE);
        ch_sel     = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            ch_sel[i] = (ir == IR_WIDTH'(CH_IR_BASE + i));
        end
`ifdef SCR1_TAPC_OVS_BLD_ID_EN
        sel_bypass = (ir == IR_BYPASS) | ~(sel_idcode | sel_bld_id | (|ch_sel));
`else
        sel_bypass = (ir == IR_BYPASS) | ~(sel_idcode | (|ch_sel));
`endif
    end

    scr1_tapc_ovs_dr #(
        .WIDTH (TAP_DR_IDCODE_W)
    ) i_idcode_dr (
        .clk           (clk),
        .rst_n         (tap_rst_n),
        .capture       (dr_capture & sel_idcode),
        .shift         (dr_shift & sel_idcode),
        .tdi           (tdi_s),
        .capture_value (fuse_idcode_i),
        .sout          (idcode_sout)
    );

    scr1_tapc_ovs_dr #(
        .WIDTH (TAP_DR_BYPASS_W)
    ) i_bypass_dr (
        .clk           (clk),
        .rst_n         (tap_rst_n),
        .capture       (dr_capture & sel_bypass),
        .shift         (dr_shift & sel_bypass),
        .tdi           (tdi_s),
        .capture_value (1'b0),
        .sout          (bypass_sout)
    );

    // Serial-out mux of the selected DR; selects are mutually exclusive
    always_comb begin
        dr_tdo = bypass_sout;
        if (sel_idcode) begin
            dr_tdo = idcode_sout;
        end
`ifdef SCR1_TAPC_OVS_BLD_ID_EN
        if (sel_bld_id) begin
            dr_tdo = bld_id_sout;
        end
`endif
        for (int i = 0; i < CH_NUM; i++) begin
            if (ch_sel[i]) begin
                dr_tdo = ch_tdo_i[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // TDO and external channel interface
    // ------------------------------------------------------------------

    // TDO changes only on a detected fall, presenting the next bit for the following rise
    always_ff @(posedge clk) begin
        if (!tap_rst_n) begin
            tapc_tdo    <= 1'b0;
            tapc_tdo_en <= 1'b0;
        end else if (tck_fall) begin
            case (state)
                TAP_SHIFT_DR: begin
                    tapc_tdo    <= dr_tdo;
                    tapc_tdo_en <= 1'b1;
                end
                TAP_SHIFT_IR: begin
                    tapc_tdo    <= ir_shift[0];
                    tapc_tdo_en <= 1'b1;
                end
                default: begin
                    tapc_tdo    <= 1'b0;
                    tapc_tdo_en <= 1'b0;
                end
            endcase
        end
    end

    // One-clk channel strobes; TDI is registered alongside so it is valid with ch_shift_o
    always_ff @(posedge clk) begin
        if (!tap_rst_n) begin
            ch_capture_o <= 1'b0;
            ch_shift_o   <= 1'b0;
            ch_update_o  <= 1'b0;
            ch_tdi_o     <= 1'b0;
        end else begin
            ch_capture_o <= dr_capture;
            ch_shift_o   <= dr_shift;
            ch_update_o  <= tck_fall & (state == TAP_UPD_DR);
            if (tck_rise) begin
                ch_tdi_o <= tdi_s;
            end
        end
    end

    // Channel selects are forced low while either reset is active
    assign ch_sel_o = tap_rst_n ? ch_sel : '0;

endmodule

// File: tb/tb_scr1_tapc_ovs.sv
// Directed bench for scr1_tapc_ovs: IDCODE, BYPASS, channel select/strobes,
// BLD_ID (or BYPASS fallback), mid-scan resets and TCK glitch rejection.
`timescale 1ns/1ps
module tb_scr1_tapc_ovs;

    localparam int CH_NUM = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              tapc_trst_n;
    logic              tapc_tck;
    logic              tapc_tms;
    logic              tapc_tdi;
    logic              tapc_tdo;
    logic              tapc_tdo_en;
    logic [31:0]       fuse_idcode_i;
    logic [CH_NUM-1:0] ch_sel_o;
    logic              ch_capture_o;
    logic              ch_shift_o;
    logic              ch_update_o;
    logic              ch_tdi_o;
    logic [CH_NUM-1:0] ch_tdo_i;

    int          checks = 0;
    int          errors = 0;
    int          cap_cnt = 0;
    int          shf_cnt = 0;
    int          upd_cnt = 0;
    logic [31:0] tdi_seen = '0;
    logic [31:0] ch_pat;
    logic        glitch_en;
    logic        en_seen;
    logic        dummy;
    logic [31:0] dout;
    logic [4:0]  ir_cap;

    always #5 clk = ~clk;

    scr1_tapc_ovs dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tapc_trst_n   (tapc_trst_n),
        .tapc_tck      (tapc_tck),
        .tapc_tms      (tapc_tms),
        .tapc_tdi      (tapc_tdi),
        .tapc_tdo      (tapc_tdo),
        .tapc_tdo_en   (tapc_tdo_en),
        .fuse_idcode_i (fuse_idcode_i),
        .ch_sel_o      (ch_sel_o),
        .ch_capture_o  (ch_capture_o),
        .ch_shift_o    (ch_shift_o),
        .ch_update_o   (ch_update_o),
        .ch_tdi_o      (ch_tdi_o),
        .ch_tdo_i      (ch_tdo_i)
    );

    // Count channel strobes and collect TDI seen with each shift strobe
    always @(negedge clk) begin
        if (ch_capture_o) cap_cnt++;
        if (ch_update_o)  upd_cnt++;
        if (ch_shift_o) begin
            shf_cnt++;
            tdi_seen = {ch_tdi_o, tdi_seen[31:1]};
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One TCK period at clk:TCK = 4:1; called at a clk negedge. Returns TDO as
    // seen just before the next fall (the bit the TAP presents for this rise).
    task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo);
        tapc_tck = 1'b0;
        tapc_tms = tms;
        tapc_tdi = tdi;
        repeat (2) @(negedge clk);
        tapc_tck = 1'b1;
        repeat (2) @(negedge clk);
        tdo = tapc_tdo;
    endtask

    // One-clk low pulse on a high TCK
    task automatic tck_glitch();
        tapc_tck = 1'b0;
        @(negedge clk);
        tapc_tck = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_tap();
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, dummy);
        tck_cycle(1'b0, 1'b0, dummy);
    endtask

    // RTI -> Shift-IR (capture done)
    task automatic enter_shift_ir();
        tck_cycle(1'b1, 1'b0, dummy);
        tck_cycle(1'b1, 1'b0, dummy);
        tck_cycle(1'b0, 1'b0, dummy);
        tck_cycle(1'b0, 1'b0, dummy);
    endtask

    task automatic scan_ir(input logic [4:0] val, output logic [4:0] cap);
        logic b;
        enter_shift_ir();
        for (int i = 0; i < 5; i++) begin
            tck_cycle(i == 4, val[i], b);
            cap[i] = b;
        end
        tck_cycle(1'b1, 1'b0, dummy);
        tck_cycle(1'b0, 1'b0, dummy);
    endtask

    task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] q);
        logic b;
        q = '0;
        tck_cycle(1'b1, 1'b0, dummy);
        tck_cycle(1'b0, 1'b0, dummy);
        tck_cycle(1'b0, 1'b0, dummy);
        for (int i = 0; i < n; i++) begin
            ch_tdo_i = {~ch_pat[i], ch_pat[i], ~ch_pat[i]};
            if (glitch_en && (i == 5 || i == 20)) tck_glitch();
            tck_cycle(i == n - 1, din[i], b);
            q[i] = b;
            if (i == 0) en_seen = tapc_tdo_en;
        end
        tck_cycle(1'b1, 1'b0, dummy);
        tck_cycle(1'b0, 1'b0, dummy);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        tapc_trst_n   = 1'b1;
        tapc_tck      = 1'b1;
        tapc_tms      = 1'b1;
        tapc_tdi      = 1'b0;
        fuse_idcode_i = 32'h1234_5677;
        ch_tdo_i      = '0;
        ch_pat        = '0;
        glitch_en     = 1'b0;
        en_seen       = 1'b0;
        repeat (4) @(negedge clk);

        // Reset state
        check("rst_tdo", tapc_tdo, 1'b0);
        check("rst_tdo_en", tapc_tdo_en, 1'b0);
        check("rst_ch_sel", ch_sel_o, 3'b000);
        check("rst_strobes", {ch_capture_o, ch_shift_o, ch_update_o}, 3'b000);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1. TLR -> IDCODE read
        reset_tap();
        scan_dr(32, 32'h0, dout);
        check("idcode", dout, 32'h1234_5677);
        check("tdo_en_shift", en_seen, 1'b1);
        check("tdo_en_idle", tapc_tdo_en, 1'b0);

        // 2. BYPASS: one-bit delay
        scan_ir(5'h1f, ir_cap);
        check("ir_capture", ir_cap, 5'h01);
        scan_dr(4, 32'hD, dout);
        check("bypass", dout[3:0], 4'b1010);

        // 3. Channel 1 select, strobes, data path
        scan_ir(5'h11, ir_cap);
        check("ch_sel", ch_sel_o, 3'b010);
        cap_cnt = 0; shf_cnt = 0; upd_cnt = 0;
        ch_pat = 32'hA6;
        scan_dr(8, 32'hC5, dout);
        repeat (2) @(negedge clk);
        check("ch_tdo", dout[7:0], 8'hA6);
        check("ch_capture_cnt", cap_cnt, 1);
        check("ch_shift_cnt", shf_cnt, 8);
        check("ch_update_cnt", upd_cnt, 1);
        check("ch_tdi", tdi_seen[31:24], 8'hC5);
        ch_pat = '0;

        // 4. BLD_ID code
        scan_ir(5'h04, ir_cap);
        check("bld_ch_sel", ch_sel_o, 3'b000);
`ifdef SCR1_TAPC_OVS_BLD_ID_EN
        scan_dr(32, 32'h0, dout);
        check("bld_id", dout, 32'h2201_1200);
`else
        scan_dr(4, 32'h6, dout);
        check("bld_bypass", dout[3:0], 4'b1100);
`endif

        // 5a. TRST low mid Shift-IR
        scan_ir(5'h11, ir_cap);
        upd_cnt = 0;
        enter_shift_ir();
        tck_cycle(1'b0, 1'b1, dummy);
        tck_cycle(1'b0, 1'b1, dummy);
        tapc_trst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("trst_ch_sel", ch_sel_o, 3'b000);
        tapc_trst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("trst_tdo_en", tapc_tdo_en, 1'b0);
        check("trst_tdo", tapc_tdo, 1'b0);
        check("trst_no_update", upd_cnt, 0);
        tck_cycle(1'b0, 1'b0, dummy);
        scan_dr(32, 32'h0, dout);
        check("trst_idcode", dout, 32'h1234_5677);

        // 5b. rst_n low mid Shift-IR
        scan_ir(5'h11, ir_cap);
        upd_cnt = 0;
        enter_shift_ir();
        tck_cycle(1'b0, 1'b1, dummy);
        tck_cycle(1'b0, 1'b1, dummy);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstn_ch_sel", ch_sel_o, 3'b000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rstn_tdo_en", tapc_tdo_en, 1'b0);
        check("rstn_no_update", upd_cnt, 0);
        tck_cycle(1'b0, 1'b0, dummy);
        scan_dr(32, 32'h0, dout);
        check("rstn_idcode", dout, 32'h1234_5677);

        // 6. TCK glitches during an IDCODE scan
        glitch_en = 1'b1;
        scan_dr(32, 32'h0, dout);
        glitch_en = 1'b0;
        check("glitch_idcode", dout, 32'h1234_5677);
        scan_dr(32, 32'h0, dout);
        check("post_glitch_idcode", dout, 32'h1234_5677);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
